// File: rtl/clock_enable_gen.sv
// clock_enable_gen: multi-channel run-time programmable clock-enable generator.
// Each channel divides clk by an effective divisor E = max(div_act, 1) and
// emits a one-cycle tick on every wrap. A new divisor is written into a
// pending register and takes effect at the next wrap, or immediately on
// sync_clr.
// Optional feature macro: CLKEN_SQUARE_EN builds the per-channel 50 % square
// outputs. Without it, sq is tied to zero.
module clock_enable_gen #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 26,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {26'd2000000, 26'd262144, 26'd4},
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              sync_clr,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pend
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pnd;
    logic             r_pend;
    logic             r_tick;

    logic [CNT_W-1:0] w_eff;
    logic             w_wrap;
    logic             w_wr_hit;
    logic             w_apply;
    logic [CNT_W-1:0] w_new_div;

    // A zero divisor behaves as one, so the channel never stalls.
    assign w_eff     = (r_div_act == '0) ? CNT_W'(1) : r_div_act;
    // >= rather than == so a counter left above E-1 still wraps.
    assign w_wrap    = (r_cnt >= (w_eff - CNT_W'(1)));
    // Addresses at or above NUM_CH never match any channel and are dropped.
    assign w_wr_hit  = div_wr && (div_ch == CH_W'(gi));
    // A write on the same edge as the apply point wins over the older pending value.
    assign w_apply   = w_wr_hit || r_pend;
    assign w_new_div = w_wr_hit ? div_val : r_div_pnd;

    // Counter, tick and divisor pending/apply handling for this channel.
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        r_cnt     <= '0;
        r_tick    <= 1'b0;
        r_pend    <= 1'b0;
        r_div_pnd <= '0;
        r_div_act <= DIV_INIT[gi*CNT_W +: CNT_W];
      end else if (sync_clr) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_pend <= 1'b0;
        if (w_apply) begin
          r_div_act <= w_new_div;
        end
        if (w_wr_hit) begin
          r_div_pnd <= div_val;
        end
      end else begin
        r_cnt  <= w_wrap ? '0 : (r_cnt + CNT_W'(1));
        r_tick <= w_wrap;
        if (w_wr_hit) begin
          r_div_pnd <= div_val;
        end
        if (w_wrap) begin
          if (w_apply) begin
            r_div_act <= w_new_div;
          end
          r_pend <= 1'b0;
        end else if (w_wr_hit) begin
          r_pend <= 1'b1;
        end
      end
    end

    assign tick[gi] = r_tick;
    assign pend[gi] = r_pend;

`ifdef CLKEN_SQUARE_EN
    logic r_sq;

    // Square output toggles whenever tick is loaded with 1 (period 2E).
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        r_sq <= 1'b0;
      end else if (sync_clr) begin
        r_sq <= 1'b0;
      end else if (w_wrap) begin
        r_sq <= ~r_sq;
      end
    end

    assign sq[gi] = r_sq;
`else
    assign sq[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// tb_clock_enable_gen: directed test of clock_enable_gen with default
// parameters. Stimulus pushes expected tick cycles per channel into queues;
// a negedge monitor pops and compares whenever a monitored tick appears.
module tb_clock_enable_gen;

`ifdef CLKEN_SQUARE_EN
  localparam logic SQ_ON = 1'b1;
`else
  localparam logic SQ_ON = 1'b0;
`endif

  logic        clk;
  logic        clr_n;
  logic        sync_clr;
  logic        div_wr;
  logic [1:0]  div_ch;
  logic [25:0] div_val;
  logic [2:0]  tick;
  logic [2:0]  sq;
  logic [2:0]  pend;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[3][$];
  logic [2:0] mon_en = 3'b000;
  int c0;
  int s;
  int r;

  clock_enable_gen dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .sync_clr (sync_clr),
    .div_wr   (div_wr),
    .div_ch   (div_ch),
    .div_val  (div_val),
    .tick     (tick),
    .sq       (sq),
    .pend     (pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges; expected tick times are expressed in this count.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed tick on a monitored channel consumes one expectation.
  always @(negedge clk) begin
    int e;
    for (int k = 0; k < 3; k++) begin
      if (mon_en[k] && tick[k]) begin
        total++;
        if (exp_q[k].size() == 0) begin
          bad++;
          $display("FAIL tick%0d_unexpected: tick seen at cyc=%0d, required no tick", k, cyc);
        end else begin
          e = exp_q[k].pop_front();
          if (e != cyc) begin
            bad++;
            $display("FAIL tick%0d_time: tick at cyc=%0d, required cyc=%0d", k, cyc, e);
          end else begin
            $display("tick ch=%0d cyc=%0d ok", k, cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cyc=%0d)", nm, act, req, cyc);
    end else begin
      $display("check %s = %0h ok (cyc=%0d)", nm, act, cyc);
    end
  endtask

  task automatic check_drained(input int k);
    total++;
    if (exp_q[k].size() != 0) begin
      bad++;
      $display("FAIL drain%0d: %0d expected ticks missing, next at cyc=%0d (now %0d)",
               k, exp_q[k].size(), exp_q[k][0], cyc);
    end else begin
      $display("drain ch=%0d ok (cyc=%0d)", k, cyc);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n    = 1'b0;
    sync_clr = 1'b0;
    div_wr   = 1'b0;
    div_ch   = 2'd0;
    div_val  = '0;
    step(3);
    chk("rst_tick", tick, 3'b000);
    chk("rst_pend", pend, 3'b000);
    chk("rst_sq", sq, 3'b000);

    // Release reset: channel 0 at E=4.
    clr_n = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 6; k++) exp_q[0].push_back(c0 + 4 * k);
    mon_en = 3'b111;
    wait_to(c0 + 4);
    chk("sq0_first_half", sq[0], SQ_ON);
    wait_to(c0 + 8);
    chk("sq0_second_half", sq[0], 1'b0);

    // Mid-period write of 10 to channel 0 while its counter is 1.
    wait_to(c0 + 21);
    div_wr = 1'b1; div_ch = 2'd0; div_val = 26'd10;
    for (int k = 1; k <= 3; k++) exp_q[0].push_back(c0 + 24 + 10 * k);
    step(1);
    div_wr = 1'b0;
    chk("pend0_set", pend[0], 1'b1);
    wait_to(c0 + 23);
    chk("pend0_hold", pend[0], 1'b1);
    step(1);
    chk("pend0_applied", pend[0], 1'b0);

    // Channel 2: write 7 then 0 (last wins), then sync_clr with ch1=5 write.
    wait_to(c0 + 55);
    div_wr = 1'b1; div_ch = 2'd2; div_val = 26'd7;
    step(1);
    div_val = 26'd0;
    step(1);
    div_wr = 1'b0;
    chk("pend2_set", pend[2], 1'b1);
    check_drained(0);
    sync_clr = 1'b1;
    div_wr = 1'b1; div_ch = 2'd1; div_val = 26'd5;
    mon_en = 3'b011;
    s = cyc + 1;
    for (int k = 1; k <= 4; k++) exp_q[0].push_back(s + 10 * k);
    for (int k = 1; k <= 8; k++) exp_q[1].push_back(s + 5 * k);
    step(1);
    sync_clr = 1'b0;
    div_wr = 1'b0;
    chk("sync_tick", tick, 3'b000);
    chk("sync_sq", sq, 3'b000);
    chk("sync_pend", pend, 3'b000);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("tick2_cont", tick[2], 1'b1);
      chk("sq2_toggle", sq[2], SQ_ON & logic'(k % 2));
    end
    // Write 1 to channel 2 on an edge that is also its wrap.
    div_wr = 1'b1; div_ch = 2'd2; div_val = 26'd1;
    step(1);
    div_wr = 1'b0;
    chk("pend2_same_edge", pend[2], 1'b0);
    chk("tick2_after_w1", tick[2], 1'b1);
    step(1);
    chk("tick2_after_w1b", tick[2], 1'b1);
    chk("sq2_after_w1", sq[2], 1'b0);

    // Out-of-range channel write is ignored.
    wait_to(s + 7);
    div_wr = 1'b1; div_ch = 2'd3; div_val = 26'd2;
    step(1);
    div_wr = 1'b0;
    chk("badch_pend", pend, 3'b000);

    // Pending write on channel 0, then asynchronous reset mid-cycle.
    wait_to(s + 42);
    check_drained(0);
    check_drained(1);
    div_wr = 1'b1; div_ch = 2'd0; div_val = 26'd9;
    step(1);
    div_wr = 1'b0;
    chk("pend0_before_rst", pend, 3'b001);
    chk("tick2_before_rst", tick[2], 1'b1);
    clr_n = 1'b0;
    #1;
    chk("async_tick", tick, 3'b000);
    chk("async_pend", pend, 3'b000);
    chk("async_sq", sq, 3'b000);
    step(2);
    clr_n = 1'b1;
    r = cyc;
    for (int k = 1; k <= 3; k++) exp_q[0].push_back(r + 4 * k);
    mon_en = 3'b111;
    wait_to(r + 4);
    chk("sq0_after_rst", sq[0], SQ_ON);
    wait_to(r + 14);
    check_drained(0);
    chk("pend_end", pend, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
